// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared mode encodings, bar colour table and timing helpers for the pattern generator
package video_pkg;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_GRAD  = 2'd2,
    MODE_SOLID = 2'd3
  } mode_e;

  // {r,g,b} on/off flags, left to right: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [2:0] BAR_RGB [8] = '{
    3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
  };

  function automatic int calc_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/video_timing_core.sv
// rtl/video_timing_core.sv - raster counters with sync/active decode; counters park at (0,0) while disabled
module video_timing_core
  import video_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HW       = $clog2(calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP)),
  parameter int VW       = $clog2(calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          enable_i,
  output logic [HW-1:0] hcnt,
  output logic [VW-1:0] vcnt,
  output logic          active,
  output logic          hsync_act,
  output logic          vsync_act,
  output logic          origin
);

  localparam int H_TOTAL  = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL  = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (!enable_i) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == HW'(H_TOTAL - 1)) begin
      hcnt <= '0;
      vcnt <= (vcnt == VW'(V_TOTAL - 1)) ? '0 : vcnt + VW'(1);
    end else begin
      hcnt <= hcnt + HW'(1);
    end
  end

  // Compare in 32 bits so a porch of zero cannot truncate the thresholds
  assign active    = (32'(hcnt) < H_ACTIVE) && (32'(vcnt) < V_ACTIVE);
  assign hsync_act = (32'(hcnt) >= HS_START) && (32'(hcnt) < HS_END);
  assign vsync_act = (32'(vcnt) >= VS_START) && (32'(vcnt) < VS_END);
  assign origin    = (hcnt == '0) && (vcnt == '0);

endmodule

// File: rtl/video_pattern_gen.sv
// rtl/video_pattern_gen.sv - programmable-timing test pattern source with frame-boundary mode latch
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIX_SZ   = 8,
  parameter int CHK_LOG2 = 5,
  localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic [1:0]            mode_i,
  input  logic [3*PIX_SZ-1:0]   solid_rgb_i,
  output logic                  hsync_o,
  output logic                  vsync_o,
  output logic                  de_o,
  output logic [PIX_SZ-1:0]     r_o,
  output logic [PIX_SZ-1:0]     g_o,
  output logic [PIX_SZ-1:0]     b_o,
  output logic [HW-1:0]         hcount_o,
  output logic [VW-1:0]         vcount_o,
  output logic                  frame_start_o,
  output logic [1:0]            mode_o
);

  localparam int unsigned BAR_W = H_ACTIVE / 8;

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          active;
  logic          hsync_act;
  logic          vsync_act;
  logic          origin;

  video_timing_core #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HW(HW), .VW(VW)
  ) u_timing (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .enable_i  (enable_i),
    .hcnt      (hcnt),
    .vcnt      (vcnt),
    .active    (active),
    .hsync_act (hsync_act),
    .vsync_act (vsync_act),
    .origin    (origin)
  );

  mode_e               mode_r;
  logic [3*PIX_SZ-1:0] solid_r;
  logic                capture;
  mode_e               mode_eff;
  logic [3*PIX_SZ-1:0] solid_eff;
  logic [2:0]          bar_idx;
  logic [2:0]          bar_rgb;
  logic                chk;
  logic [3*PIX_SZ-1:0] pix;

  // Pixel (0,0) itself must already use the newly captured settings, so bypass the latch there
  assign capture   = enable_i && origin;
  assign mode_eff  = capture ? mode_e'(mode_i) : mode_r;
  assign solid_eff = capture ? solid_rgb_i : solid_r;

  assign bar_idx = 3'(32'(hcnt) / BAR_W);
  assign bar_rgb = BAR_RGB[bar_idx];
  assign chk     = 1'((32'(hcnt) >> CHK_LOG2) ^ (32'(vcnt) >> CHK_LOG2));

  always_comb begin
    pix = '0;
    case (mode_eff)
      MODE_BARS:  pix = {{PIX_SZ{bar_rgb[2]}}, {PIX_SZ{bar_rgb[1]}}, {PIX_SZ{bar_rgb[0]}}};
      MODE_CHECK: pix = chk ? '1 : '0;
      MODE_GRAD:  pix = {3{PIX_SZ'(hcnt)}};
      MODE_SOLID: pix = solid_eff;
      default:    pix = '0;
    endcase
    if (!active) begin
      pix = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_r        <= MODE_BARS;
      solid_r       <= '0;
      mode_o        <= 2'd0;
      de_o          <= 1'b0;
      hsync_o       <= ~HS_POL;
      vsync_o       <= ~VS_POL;
      r_o           <= '0;
      g_o           <= '0;
      b_o           <= '0;
      hcount_o      <= '0;
      vcount_o      <= '0;
      frame_start_o <= 1'b0;
    end else begin
      if (capture) begin
        mode_r  <= mode_eff;
        solid_r <= solid_eff;
      end
      mode_o <= mode_eff;
      if (enable_i) begin
        de_o              <= active;
        hsync_o           <= hsync_act ? HS_POL : ~HS_POL;
        vsync_o           <= vsync_act ? VS_POL : ~VS_POL;
        {r_o, g_o, b_o}   <= pix;
        hcount_o          <= hcnt;
        vcount_o          <= vcnt;
        frame_start_o     <= origin;
      end else begin
        de_o              <= 1'b0;
        hsync_o           <= ~HS_POL;
        vsync_o           <= ~VS_POL;
        {r_o, g_o, b_o}   <= '0;
        hcount_o          <= '0;
        vcount_o          <= '0;
        frame_start_o     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// tb/tb_video_pattern_gen.sv - scoreboard bench for video_pattern_gen against a frame-position reference model
module tb_video_pattern_gen;

  localparam int HA = 16, HFP = 2, HSY = 3, HBP = 3;
  localparam int VA = 4, VFP = 1, VSY = 1, VBP = 1;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FRAME = HT * VT;
  localparam int HW = $clog2(HT);
  localparam int VW = $clog2(VT);
  localparam bit HS_POL = 1'b0;
  localparam bit VS_POL = 1'b0;
  localparam int CHK = 2;

  typedef struct {
    int hs; int vs; int de; int fs;
    int r; int g; int b;
    int r3; int g3; int b3;
    int hc; int vc; int mode;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        enable_i = 1'b0;
  logic [1:0]  mode_i = 2'd0;
  logic [23:0] solid_rgb_i = 24'h0;
  logic [8:0]  solid3;

  logic hsync_o, vsync_o, de_o, frame_start_o;
  logic [7:0] r_o, g_o, b_o;
  logic [HW-1:0] hcount_o;
  logic [VW-1:0] vcount_o;
  logic [1:0] mode_o;

  logic hs3, vs3, de3, fs3;
  logic [2:0] r3, g3, b3;
  logic [HW-1:0] hc3;
  logic [VW-1:0] vc3;
  logic [1:0] mode3;

  assign solid3 = {solid_rgb_i[18:16], solid_rgb_i[10:8], solid_rgb_i[2:0]};

  always #5 clk = ~clk;

  video_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .PIX_SZ(8), .CHK_LOG2(1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .enable_i(enable_i), .mode_i(mode_i),
    .solid_rgb_i(solid_rgb_i), .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o),
    .r_o(r_o), .g_o(g_o), .b_o(b_o), .hcount_o(hcount_o), .vcount_o(vcount_o),
    .frame_start_o(frame_start_o), .mode_o(mode_o)
  );

  video_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .PIX_SZ(3), .CHK_LOG2(1)
  ) dut3 (
    .clk_i(clk), .rst_ni(rst_ni), .enable_i(enable_i), .mode_i(mode_i),
    .solid_rgb_i(solid3), .hsync_o(hs3), .vsync_o(vs3), .de_o(de3),
    .r_o(r3), .g_o(g3), .b_o(b3), .hcount_o(hc3), .vcount_o(vc3),
    .frame_start_o(fs3), .mode_o(mode3)
  );

  exp_t q[$];
  int n_vec = 0;
  int n_bad = 0;

  // Reference state: linear pixel position within the frame plus the latched frame settings
  int pos = 0;
  int m_mode = 0;
  logic [23:0] m_solid = 24'h0;
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  task automatic chk(input string nm, input int a, input int e, inout bit bad);
    if (a != e) begin
      $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, a, e);
      bad = 1'b1;
    end
  endtask

  task automatic cycle(input bit rst, input bit en, input int mode, input logic [23:0] solid);
    exp_t e;
    int x, y;
    logic [23:0] c;
    @(negedge clk);
    rst_ni = rst;
    enable_i = en;
    mode_i = 2'(mode);
    solid_rgb_i = solid;
    e = '{default: 0};
    e.hs = int'(!HS_POL);
    e.vs = int'(!VS_POL);
    if (!rst) begin
      pos = 0;
      m_mode = 0;
      m_solid = 24'h0;
    end else if (!en) begin
      pos = 0;
    end else begin
      if (pos == 0) begin
        m_mode = mode;
        m_solid = solid;
      end
      x = pos % HT;
      y = pos / HT;
      e.hc = x;
      e.vc = y;
      e.fs = int'(pos == 0);
      e.de = int'(x < HA && y < VA);
      if (x >= HA + HFP && x < HA + HFP + HSY) e.hs = int'(HS_POL);
      if (y >= VA + VFP && y < VA + VFP + VSY) e.vs = int'(VS_POL);
      if (e.de != 0) begin
        case (m_mode)
          0: c = bars[x / (HA / 8)];
          1: c = (((x / CHK) + (y / CHK)) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
          2: c = {3{8'(x % 256)}};
          default: c = m_solid;
        endcase
        e.r = int'(c[23:16]);
        e.g = int'(c[15:8]);
        e.b = int'(c[7:0]);
        if (m_mode == 2) begin
          e.r3 = x % 8; e.g3 = x % 8; e.b3 = x % 8;
        end else if (m_mode == 3) begin
          e.r3 = int'(c[18:16]); e.g3 = int'(c[10:8]); e.b3 = int'(c[2:0]);
        end else begin
          e.r3 = (e.r != 0) ? 7 : 0;
          e.g3 = (e.g != 0) ? 7 : 0;
          e.b3 = (e.b != 0) ? 7 : 0;
        end
      end
      pos = (pos + 1) % FRAME;
    end
    e.mode = m_mode;
    q.push_back(e);
  endtask

  task automatic run_until(input int target, input int mode, input logic [23:0] solid);
    int guard;
    guard = 0;
    while (pos != target && guard < 1000) begin
      cycle(1'b1, 1'b1, mode, solid);
      guard++;
    end
    n_vec++;
    if (pos != target) begin
      $display("FAIL run_until: position %0d, expected %0d", pos, target);
      n_bad++;
    end
  endtask

  task automatic reset_now();
    bit bad;
    bad = 1'b0;
    cycle(1'b0, 1'b0, 0, 24'h0);
    #1;
    chk("rst_de", int'(de_o), 0, bad);
    chk("rst_hsync", int'(hsync_o), int'(!HS_POL), bad);
    chk("rst_vsync", int'(vsync_o), int'(!VS_POL), bad);
    chk("rst_rgb", int'({r_o, g_o, b_o}), 0, bad);
    chk("rst_hcount", int'(hcount_o), 0, bad);
    chk("rst_vcount", int'(vcount_o), 0, bad);
    chk("rst_fs", int'(frame_start_o), 0, bad);
    chk("rst_mode", int'(mode_o), 0, bad);
    n_vec++;
    if (bad) n_bad++;
  endtask

  // Monitor: every clock presents one output pixel; pop and compare just after the edge
  exp_t me;
  bit mbad;
  always begin
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      me = q.pop_front();
      mbad = 1'b0;
      chk("de", int'(de_o), me.de, mbad);
      chk("hsync", int'(hsync_o), me.hs, mbad);
      chk("vsync", int'(vsync_o), me.vs, mbad);
      chk("frame_start", int'(frame_start_o), me.fs, mbad);
      chk("hcount", int'(hcount_o), me.hc, mbad);
      chk("vcount", int'(vcount_o), me.vc, mbad);
      chk("mode", int'(mode_o), me.mode, mbad);
      chk("r", int'(r_o), me.r, mbad);
      chk("g", int'(g_o), me.g, mbad);
      chk("b", int'(b_o), me.b, mbad);
      chk("de3", int'(de3), me.de, mbad);
      chk("hsync3", int'(hs3), me.hs, mbad);
      chk("vsync3", int'(vs3), me.vs, mbad);
      chk("frame_start3", int'(fs3), me.fs, mbad);
      chk("hcount3", int'(hc3), me.hc, mbad);
      chk("vcount3", int'(vc3), me.vc, mbad);
      chk("mode3", int'(mode3), me.mode, mbad);
      chk("r3", int'(r3), me.r3, mbad);
      chk("g3", int'(g3), me.g3, mbad);
      chk("b3", int'(b3), me.b3, mbad);
      n_vec++;
      if (mbad) n_bad++;
    end
  end

  initial begin
    int rm, off;
    logic [23:0] rs;
    rm = 0;
    off = 0;
    rs = 24'h0;

    repeat (3) cycle(1'b0, 1'b0, 0, 24'h0);
    repeat (2) cycle(1'b1, 1'b0, 0, 24'h0);

    // Bars for two frames, then switch to solid at line 2
    repeat (2 * FRAME) cycle(1'b1, 1'b1, 0, 24'h0);
    run_until(2 * HT, 0, 24'h0);
    repeat (2 * FRAME) cycle(1'b1, 1'b1, 3, 24'h123456);

    repeat (2 * FRAME) cycle(1'b1, 1'b1, 1, 24'h0);
    repeat (2 * FRAME) cycle(1'b1, 1'b1, 2, 24'h0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3) rm = int'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 3) rs = 24'($urandom);
      if (off == 0 && $urandom_range(0, 299) == 0) off = int'($urandom_range(1, 5));
      cycle(1'b1, off == 0, rm, rs);
      if (off > 0) off--;
    end

    // Drop enable with the counters at (5,2), then restart
    run_until(2 * HT + 5, 0, 24'h0);
    repeat (4) cycle(1'b1, 1'b0, 0, 24'h0);
    repeat (FRAME + 20) cycle(1'b1, 1'b1, 0, 24'h0);

    // Asynchronous reset mid-frame
    run_until(3 * HT + 7, 3, 24'hA5C3E1);
    reset_now();
    cycle(1'b0, 1'b1, 0, 24'h0);
    repeat (FRAME + 20) cycle(1'b1, 1'b1, 1, 24'h0);

    repeat (2) @(posedge clk);
    #2;
    n_vec++;
    if (q.size() != 0) begin
      $display("FAIL drain: %0d expected outputs never compared, expected 0", q.size());
      n_bad++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
